seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen.sv | 115 +++++++++++
 tb/tb_seq_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Serial frame generator: shifts out len bits of a latched pattern MSB-first,
// then holds a one-cycle DONE state that pulses done and counts the frame.
module seq_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] pattern,
  input  logic [3:0]   len,
  input  logic         abort,
  output logic         x,
  output logic         x_valid,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   q,
  output logic [7:0]   frame_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEND   = 2'b01,
    DONE   = 2'b10,
    UNUSED = 2'b11
  } state_t;

  localparam logic [3:0] LEN_MAX = 4'(W);

  state_t       state_q, state_d;
  logic [W-1:0] shift_q, shift_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic         x_q, x_d;
  logic         x_valid_q, x_valid_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;
  logic         len_ok;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    x_d         = 1'b0;
    x_valid_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    len_ok      = (len != 4'd0) && (len <= LEN_MAX);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            // Left-align so the first bit to send always sits at the MSB.
            shift_d   = pattern << (LEN_MAX - len);
            bit_cnt_d = len;
            state_d   = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (abort) begin
          state_d   = IDLE;
          shift_d   = '0;
          bit_cnt_d = 4'd0;
        end else if (bit_cnt_q != 4'd0) begin
          x_d       = shift_q[W-1];
          x_valid_d = 1'b1;
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q - 4'd1;
        end else begin
          state_d     = DONE;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= 4'd0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;
  assign q         = state_q;
  assign busy      = (state_q == SEND) || (state_q == DONE);

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: per-cycle expected outputs are queued when a frame is
// launched and popped one per clock as the DUT produces them.
module tb_seq_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       abort;
  logic       x, x_valid, busy, done, err;
  logic [1:0] q;
  logic [7:0] frame_cnt;

  seq_gen #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .abort     (abort),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .q         (q),
    .frame_cnt (frame_cnt)
  );

  typedef struct packed {
    logic [1:0] q;
    logic       x;
    logic       xv;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    bit         abort_with_start;
    bit         abort_in_done;
  } vec_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model_cnt = 8'd0;
  vec_t       vecs[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] s, input logic xb, input logic xv,
                              input logic by, input logic dn, input logic er,
                              input logic [7:0] c);
    exp_t e;
    e.q = s; e.x = xb; e.xv = xv; e.busy = by; e.done = dn; e.err = er; e.cnt = c;
    return e;
  endfunction

  task automatic check(input string name, input exp_t e);
    exp_t a;
    a = {q, x, x_valid, busy, done, err, frame_cnt};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got q=%b x=%b xv=%b busy=%b done=%b err=%b cnt=%0d, want q=%b x=%b xv=%b busy=%b done=%b err=%b cnt=%0d",
               name, $time, a.q, a.x, a.xv, a.busy, a.done, a.err, a.cnt,
               e.q, e.x, e.xv, e.busy, e.done, e.err, e.cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected trace for one frame launched from IDLE with the given inputs.
  task automatic push_frame(input logic [7:0] pat, input logic [3:0] l);
    if (l >= 4'd1 && l <= 4'd8) begin
      sb.push_back(mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, model_cnt));
      for (int i = int'(l) - 1; i >= 0; i--)
        sb.push_back(mk(2'b01, pat[i], 1'b1, 1'b1, 1'b0, 1'b0, model_cnt));
      model_cnt = model_cnt + 8'd1;
      sb.push_back(mk(2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, model_cnt));
      sb.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_cnt));
    end else begin
      sb.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_cnt));
      sb.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_cnt));
    end
  endtask

  task automatic drain(input string name, input int release_start_at,
                       input int abort_at, input bit scramble);
    int idx;
    exp_t e;
    idx = 0;
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      check(name, e);
      if (idx == release_start_at) start = 1'b0;
      abort = (idx == abort_at);
      if (scramble && idx == 0) begin
        pattern = 8'($urandom);
        len     = 4'($urandom_range(0, 15));
      end
      idx++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 1000000", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h96, 4'd8,  1'b0, 1'b0};
    vecs[1] = '{8'h0B, 4'd4,  1'b0, 1'b0};
    vecs[2] = '{8'hFF, 4'd0,  1'b0, 1'b0};
    vecs[3] = '{8'hFF, 4'd9,  1'b0, 1'b0};
    vecs[4] = '{8'h5A, 4'd1,  1'b0, 1'b0};
    vecs[5] = '{8'hC3, 4'd8,  1'b1, 1'b0};
    vecs[6] = '{8'h3C, 4'd5,  1'b0, 1'b1};
    vecs[7] = '{8'h81, 4'd15, 1'b0, 1'b0};
    vecs[8] = '{8'hA7, 4'd3,  1'b0, 1'b0};

    reset = 1'b0; start = 1'b0; abort = 1'b0; pattern = 8'h00; len = 4'd0;
    #3;
    check("reset_pre_clk", mk(2'b00, 0, 0, 0, 0, 0, 8'd0));
    start = 1'b1; len = 4'd4; pattern = 8'hFF;
    tick(); tick();
    check("reset_held", mk(2'b00, 0, 0, 0, 0, 0, 8'd0));
    start = 1'b0;
    reset = 1'b1;

    // Table: first entry is launched on the very first edge after release.
    foreach (vecs[v]) begin
      pattern = vecs[v].pat;
      len     = vecs[v].len;
      abort   = vecs[v].abort_with_start;
      start   = 1'b1;
      push_frame(vecs[v].pat, vecs[v].len);
      drain($sformatf("vec%0d", v), 0,
            vecs[v].abort_in_done ? int'(vecs[v].len) + 1 : -1, 1'b1);
    end

    // start held high through SEND and DONE: exactly one extra frame.
    pattern = 8'h0B; len = 4'd4; start = 1'b1;
    push_frame(8'h0B, 4'd4);
    push_frame(8'h0B, 4'd4);
    drain("start_held", 7, -1, 1'b0);
    tick();
    check("start_held_idle", mk(2'b00, 0, 0, 0, 0, 0, model_cnt));

    // Abort on the third bit of an 8-bit frame.
    pattern = 8'hA5; len = 4'd8; start = 1'b1;
    sb.push_back(mk(2'b01, 0, 0, 1, 0, 0, model_cnt));
    sb.push_back(mk(2'b01, 1, 1, 1, 0, 0, model_cnt));
    sb.push_back(mk(2'b01, 0, 1, 1, 0, 0, model_cnt));
    sb.push_back(mk(2'b01, 1, 1, 1, 0, 0, model_cnt));
    for (int i = 0; i < 4; i++)
      sb.push_back(mk(2'b00, 0, 0, 0, 0, 0, model_cnt));
    drain("abort_send", 0, 3, 1'b1);

    // Asynchronous reset between edges in the middle of a frame.
    pattern = 8'hFF; len = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("pre_async_reset", mk(2'b01, 1, 1, 1, 0, 0, model_cnt));
    #2 reset = 1'b0;
    #1;
    model_cnt = 8'd0;
    check("async_reset", mk(2'b00, 0, 0, 0, 0, 0, 8'd0));
    tick(); tick();
    check("async_reset_held", mk(2'b00, 0, 0, 0, 0, 0, 8'd0));
    #2 reset = 1'b1;
    for (int i = 0; i < 12; i++)
      sb.push_back(mk(2'b00, 0, 0, 0, 0, 0, 8'd0));
    drain("post_reset_idle", -1, -1, 1'b0);

    // 256 completed frames bring frame_cnt back to zero.
    for (int f = 0; f < 256; f++) begin
      pattern = 8'($urandom);
      len     = 4'($urandom_range(1, 8));
      start   = 1'b1;
      push_frame(pattern, len);
      drain("wrap_frames", 0, -1, 1'b1);
    end
    n_cmp++;
    if (frame_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL cnt_wrap: got frame_cnt=%0d, want 0", frame_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
